// File: rtl/pc_flow_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_flow_sequencer_if
//  Description : Bundles the fetch-side inputs and the PC-control outputs of
//                the flow-control sequencer.
//                  master : fetch / PC-control side (drives instruction
//                           stream, observes control pulses)
//                  slave  : sequencer side (consumes instruction stream,
//                           drives control pulses)
//  Signals     : pause, instr[15:0], instr_valid, zero_flag, irq_req  (to seq)
//                goto, goto_addr[11:0], ret, skip, interrupt, gie,
//                depth[3:0], stack_error                          (from seq)
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_flow_sequencer_if;
    logic        pause;
    logic [15:0] instr;
    logic        instr_valid;
    logic        zero_flag;
    logic        irq_req;

    logic        goto;
    logic [11:0] goto_addr;
    logic        ret;
    logic        skip;
    logic        interrupt;
    logic        gie;
    logic [3:0]  depth;
    logic        stack_error;

    modport master (
        output pause, instr, instr_valid, zero_flag, irq_req,
        input  goto, goto_addr, ret, skip, interrupt, gie, depth, stack_error
    );

    modport slave (
        input  pause, instr, instr_valid, zero_flag, irq_req,
        output goto, goto_addr, ret, skip, interrupt, gie, depth, stack_error
    );
endinterface
`default_nettype wire

// File: rtl/pc_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_flow_sequencer
//  Description : Flow-control sequencer for the 8-bit CPU front end. Decodes
//                fetched instruction words into goto / ret / skip pulses,
//                arbitrates the level-sensitive interrupt request against the
//                global enable, and tracks return-stack occupancy so that no
//                push past capacity or pop from empty is ever issued.
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous, active-high clear
//                bus (slave)  - pause, instr, instr_valid, zero_flag, irq_req
//                               in; goto, goto_addr, ret, skip, interrupt,
//                               gie, depth, stack_error out
//  Parameters  : STACK_DEPTH  - return-stack capacity (1..15)
//                IRQ_LATENCY  - slots discarded after an interrupt (>= 1)
//  Revision    : 1.0  initial release
// ============================================================================
module pc_flow_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int IRQ_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    pc_flow_sequencer_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_FLUSH    = 2'd1;
    localparam logic [1:0] c_ST_IRQ_WAIT = 2'd2;

    localparam logic [3:0] c_OP_GOTO   = 4'hA;
    localparam logic [3:0] c_OP_SKIPZ  = 4'hB;
    localparam logic [3:0] c_OP_SKIPNZ = 4'hC;
    localparam logic [3:0] c_OP_RET    = 4'hD;
    localparam logic [3:0] c_OP_MISC   = 4'hE;

    localparam logic [11:0] c_EI_CODE = 12'h001;
    localparam logic [11:0] c_DI_CODE = 12'h002;

    localparam logic [3:0] c_STACK_DEPTH = 4'(STACK_DEPTH);

    // The wait counter starts at IRQ_LATENCY-1 and counts down to 0, one
    // discarded slot per edge, so IRQ_LATENCY slots are dropped in total.
    localparam int                 c_CNT_W    = (IRQ_LATENCY > 1) ? $clog2(IRQ_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(IRQ_LATENCY - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_goto;
    logic [11:0]        r_goto_addr;
    logic               r_ret;
    logic               r_skip;
    logic               r_interrupt;
    logic               r_gie;
    logic [3:0]         r_depth;
    logic               r_stack_error;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_goto_nxt;
    logic [11:0]        w_goto_addr_nxt;
    logic               w_ret_nxt;
    logic               w_skip_nxt;
    logic               w_interrupt_nxt;
    logic               w_gie_nxt;
    logic [3:0]         w_depth_nxt;
    logic               w_stack_error_nxt;

    // ------------------------------------------------------------------------
    // Instruction decode (only meaningful while the state machine is in RUN)
    // ------------------------------------------------------------------------
    logic [3:0]  w_opcode;
    logic [11:0] w_operand;
    logic        w_dec_goto;
    logic        w_dec_skip_taken;
    logic        w_dec_ret;
    logic        w_dec_retfie;
    logic        w_dec_ei;
    logic        w_dec_di;
    logic        w_flow_op;
    logic        w_stack_full;
    logic        w_stack_empty;
    logic        w_irq_take;

    assign w_opcode  = bus.instr[15:12];
    assign w_operand = bus.instr[11:0];

    assign w_dec_goto       = bus.instr_valid && (w_opcode == c_OP_GOTO);
    assign w_dec_skip_taken = bus.instr_valid &&
                              (((w_opcode == c_OP_SKIPZ)  &&  bus.zero_flag) ||
                               ((w_opcode == c_OP_SKIPNZ) && !bus.zero_flag));
    assign w_dec_ret        = bus.instr_valid && (w_opcode == c_OP_RET);
    assign w_dec_retfie     = w_dec_ret && bus.instr[0];
    assign w_dec_ei         = bus.instr_valid && (w_opcode == c_OP_MISC) && (w_operand == c_EI_CODE);
    assign w_dec_di         = bus.instr_valid && (w_opcode == c_OP_MISC) && (w_operand == c_DI_CODE);

    // A flow op is anything that redirects the PC and therefore needs the
    // in-flight fetch flushed; an untaken skip is not one, so an interrupt
    // may still be taken alongside it.
    assign w_flow_op = w_dec_goto || w_dec_skip_taken || w_dec_ret;

    assign w_stack_full  = (r_depth >= c_STACK_DEPTH);
    assign w_stack_empty = (r_depth == 4'd0);

    // A request at full depth is simply not taken; it stays pending because
    // irq_req is level-sensitive and will be re-evaluated after a return.
    assign w_irq_take = bus.irq_req && r_gie && !w_flow_op && !w_stack_full;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_cnt         <= '0;
            r_goto        <= 1'b0;
            r_goto_addr   <= 12'h000;
            r_ret         <= 1'b0;
            r_skip        <= 1'b0;
            r_interrupt   <= 1'b0;
            r_gie         <= 1'b0;
            r_depth       <= 4'd0;
            r_stack_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_goto        <= w_goto_nxt;
            r_goto_addr   <= w_goto_addr_nxt;
            r_ret         <= w_ret_nxt;
            r_skip        <= w_skip_nxt;
            r_interrupt   <= w_interrupt_nxt;
            r_gie         <= w_gie_nxt;
            r_depth       <= w_depth_nxt;
            r_stack_error <= w_stack_error_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // Pulses default to 0 every edge, which gives the one-cycle width and
    // makes them drop on a paused edge; everything else holds by default.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_goto_nxt        = 1'b0;
        w_goto_addr_nxt   = r_goto_addr;
        w_ret_nxt         = 1'b0;
        w_skip_nxt        = 1'b0;
        w_interrupt_nxt   = 1'b0;
        w_gie_nxt         = r_gie;
        w_depth_nxt       = r_depth;
        w_stack_error_nxt = r_stack_error;

        if (!bus.pause) begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_flow_op) begin
                        w_state_nxt = c_ST_FLUSH;
                        if (w_dec_goto) begin
                            w_goto_nxt      = 1'b1;
                            w_goto_addr_nxt = w_operand;
                        end
                        if (w_dec_skip_taken) begin
                            w_skip_nxt = 1'b1;
                        end
                        if (w_dec_ret) begin
                            // Popping an empty stack is suppressed and flagged
                            // rather than passed on to the PC control.
                            if (w_stack_empty) begin
                                w_stack_error_nxt = 1'b1;
                            end else begin
                                w_ret_nxt   = 1'b1;
                                w_depth_nxt = r_depth - 4'd1;
                            end
                        end
                        if (w_dec_retfie) begin
                            w_gie_nxt = 1'b1;
                        end
                    end else if (w_irq_take) begin
                        // The instruction on this edge is dropped; the PC
                        // control pushes its address and replays it later.
                        w_interrupt_nxt = 1'b1;
                        w_gie_nxt       = 1'b0;
                        w_depth_nxt     = r_depth + 4'd1;
                        w_state_nxt     = c_ST_IRQ_WAIT;
                        w_cnt_nxt       = c_CNT_INIT;
                    end else if (w_dec_ei) begin
                        w_gie_nxt = 1'b1;
                    end else if (w_dec_di) begin
                        w_gie_nxt = 1'b0;
                    end
                end

                c_ST_FLUSH: begin
                    // One slot is thrown away regardless of instr_valid.
                    w_state_nxt = c_ST_RUN;
                end

                c_ST_IRQ_WAIT: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = c_ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.goto        = r_goto;
    assign bus.goto_addr   = r_goto_addr;
    assign bus.ret         = r_ret;
    assign bus.skip        = r_skip;
    assign bus.interrupt   = r_interrupt;
    assign bus.gie         = r_gie;
    assign bus.depth       = r_depth;
    assign bus.stack_error = r_stack_error;

endmodule
`default_nettype wire

// File: tb/tb_pc_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_flow_sequencer
//  Description : Scoreboard bench for pc_flow_sequencer. The driver applies
//                one stimulus slot per cycle and pushes the expected
//                registered outputs from a slot-level reference model; an
//                independent monitor pops and compares after every edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_flow_sequencer;

    localparam int STACK_DEPTH = 8;
    localparam int IRQ_LATENCY = 3;

    logic clk;
    logic reset;

    pc_flow_sequencer_if bus ();

    pc_flow_sequencer #(
        .STACK_DEPTH (STACK_DEPTH),
        .IRQ_LATENCY (IRQ_LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // {goto, goto_addr[11:0], ret, skip, interrupt, gie, depth[3:0], stack_error}
    logic [21:0] exp_q[$];

    // ------------------------------------------------------------------------
    // Reference model: works in instruction slots. 'm_busy' is the number of
    // upcoming slots that will be thrown away.
    // ------------------------------------------------------------------------
    int          m_busy;
    bit          m_gie;
    int          m_depth;
    bit          m_err;
    logic [11:0] m_addr;

    task automatic model_reset();
        m_busy  = 0;
        m_gie   = 0;
        m_depth = 0;
        m_err   = 0;
        m_addr  = 12'h000;
    endtask

    task automatic model_step(input bit p, input logic [15:0] ins, input bit v,
                              input bit zf, input bit irq);
        bit g = 0, r = 0, s = 0, it = 0;
        bit redirect;
        logic [3:0] op;
        op = ins[15:12];
        if (!p) begin
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end else begin
                redirect = v && (op == 4'hA || op == 4'hD ||
                                 (op == 4'hB && zf) || (op == 4'hC && !zf));
                if (redirect) begin
                    m_busy = 1;
                    if (op == 4'hA) begin
                        g = 1;
                        m_addr = ins[11:0];
                    end else if (op == 4'hD) begin
                        if (m_depth > 0) begin
                            r = 1;
                            m_depth = m_depth - 1;
                        end else begin
                            m_err = 1;
                        end
                        if (ins[0]) m_gie = 1;
                    end else begin
                        s = 1;
                    end
                end else if (irq && m_gie && m_depth < STACK_DEPTH) begin
                    it = 1;
                    m_gie = 0;
                    m_depth = m_depth + 1;
                    m_busy = IRQ_LATENCY;
                end else if (v && op == 4'hE && ins[11:0] == 12'h001) begin
                    m_gie = 1;
                end else if (v && op == 4'hE && ins[11:0] == 12'h002) begin
                    m_gie = 0;
                end
            end
        end
        exp_q.push_back({g, m_addr, r, s, it, m_gie, 4'(m_depth), m_err});
    endtask

    function automatic logic [21:0] dut_vec();
        return {bus.goto, bus.goto_addr, bus.ret, bus.skip, bus.interrupt,
                bus.gie, bus.depth, bus.stack_error};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: one expected snapshot per edge, sampled 1 time unit after it.
    // ------------------------------------------------------------------------
    initial begin
        logic [21:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", 32'(dut_vec()), 32'(e));
                check("one_pulse", 32'($countones({bus.goto, bus.ret, bus.skip, bus.interrupt}) <= 1), 32'd1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers. Called at posedge+3; return at the next posedge+3, so
    // the DUT outputs then reflect the slot just applied.
    // ------------------------------------------------------------------------
    task automatic step(input bit p, input logic [15:0] ins, input bit v,
                        input bit zf, input bit irq);
        bus.pause       = p;
        bus.instr       = ins;
        bus.instr_valid = v;
        bus.zero_flag   = zf;
        bus.irq_req     = irq;
        model_step(p, ins, v, zf, irq);
        @(posedge clk);
        #3;
    endtask

    task automatic run(input logic [15:0] ins, input bit irq);
        step(1'b0, ins, 1'b1, 1'b0, irq);
    endtask

    task automatic do_reset();
        exp_q.delete();
        reset = 1'b1;
        bus.pause = 1'b0; bus.instr = 16'h0000; bus.instr_valid = 1'b0;
        bus.zero_flag = 1'b0; bus.irq_req = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    localparam logic [15:0] NOP = 16'h0123;
    localparam logic [15:0] EI  = 16'hE001;
    localparam logic [15:0] DI  = 16'hE002;

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        bus.pause = 1'b0; bus.instr = 16'h0000; bus.instr_valid = 1'b0;
        bus.zero_flag = 1'b0; bus.irq_req = 1'b0;
        #3;
        do_reset();

        // Plain instructions after reset: nothing happens.
        run(NOP, 0); run(16'h5555, 0); run(16'h0FFF, 0);

        // GOTO, discarded follower, then a second GOTO.
        run(16'hA123, 0);
        check("goto_first", {19'd0, bus.goto, bus.goto_addr}, {19'd0, 1'b1, 12'h123});
        run(16'hA456, 0);
        check("goto_discard", 32'(bus.goto), 32'd0);
        run(16'hA456, 0);
        check("goto_second", 32'(bus.goto_addr), 32'h456);
        run(NOP, 0);

        // Skips both ways.
        step(0, 16'hB000, 1, 1, 0);
        check("skipz_taken", 32'(bus.skip), 32'd1);
        run(NOP, 0);
        step(0, 16'hB000, 1, 0, 0);
        check("skipz_not", 32'(bus.skip), 32'd0);
        step(0, 16'hC000, 1, 0, 0);
        check("skipnz_taken", 32'(bus.skip), 32'd1);
        run(NOP, 0);
        step(0, 16'hC000, 1, 1, 0);
        check("skipnz_not", 32'(bus.skip), 32'd0);

        // Interrupt and RETFIE.
        run(EI, 0);
        run(NOP, 1);
        check("irq_pulse", {bus.interrupt, bus.gie, bus.depth}, {1'b1, 1'b0, 4'd1});
        run(16'hA777, 0); run(16'hA777, 0); run(16'hA777, 0);
        check("irq_discard", 32'(bus.goto), 32'd0);
        run(16'hD001, 0);
        check("retfie", {bus.ret, bus.gie, bus.depth}, {1'b1, 1'b1, 4'd0});
        run(NOP, 0);

        // Nested interrupts up to capacity, then an unserviced request.
        for (int i = 0; i < STACK_DEPTH; i++) begin
            run(EI, 0);
            run(NOP, 1);
            for (int k = 0; k < IRQ_LATENCY; k++) run(NOP, 0);
        end
        check("depth_full", 32'(bus.depth), STACK_DEPTH);
        run(EI, 0);
        run(NOP, 1);
        check("irq_at_full", {bus.interrupt, bus.stack_error, bus.depth}, {1'b0, 1'b0, 4'(STACK_DEPTH)});
        run(NOP, 1);
        run(DI, 0);
        for (int i = 0; i < STACK_DEPTH; i++) begin
            run(16'hD000, 0);
            run(NOP, 0);
        end
        check("depth_empty", 32'(bus.depth), 32'd0);
        run(16'hD000, 0);
        check("underflow", {bus.ret, bus.stack_error, bus.depth}, {1'b0, 1'b1, 4'd0});
        run(NOP, 0);

        // GOTO colliding with a pending interrupt.
        run(EI, 0);
        run(16'hA321, 1);
        check("collide_goto", {bus.goto, bus.interrupt}, 2'b10);
        run(NOP, 1);
        check("collide_flush", {bus.goto, bus.interrupt}, 2'b00);
        run(NOP, 1);
        check("collide_irq", {bus.goto, bus.interrupt}, 2'b01);
        for (int k = 0; k < IRQ_LATENCY; k++) run(NOP, 0);

        // Reset in the middle of IRQ_WAIT, then a GOTO is accepted at once.
        do_reset();
        run(EI, 0);
        run(NOP, 1);
        run(NOP, 0);
        do_reset();
        run(16'hA0F0, 0);
        check("after_reset_goto", {bus.goto, bus.goto_addr}, {1'b1, 12'h0F0});
        run(NOP, 0);

        // Randomised traffic with pauses.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    ins[15:12] = 4'hA;
                2:       ins[15:12] = 4'hB;
                3:       ins[15:12] = 4'hC;
                4:       ins[15:12] = 4'hD;
                5:       ins = ($urandom_range(0, 1) != 0) ? EI : DI;
                6:       ins[15:12] = 4'hE;
                default: ins[15:12] = 4'($urandom_range(0, 9));
            endcase
            step($urandom_range(0, 9) == 0, ins, $urandom_range(0, 4) != 0,
                 1'($urandom), $urandom_range(0, 2) == 0);
        end
        run(NOP, 0);
        run(NOP, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_flow_sequencer.md
# pc_flow_sequencer

Flow-control sequencer for the 8-bit CPU front end. Sits downstream of the program counter and instruction fetch and drives that block's control inputs: it decodes each fetched instruction word and issues `goto`/`goto_addr`, `ret`, `skip` and `interrupt` pulses back into the program counter control. It also arbitrates the external interrupt request against a global enable and tracks return-stack depth so that it never issues a push past capacity or a pop from an empty stack.

## Interface
- `STACK_DEPTH`, 8: return-stack capacity shared with the PC control; valid range 1..15.
- `IRQ_LATENCY`, 3: instruction slots discarded after an interrupt is issued (the PC control takes two cycles to vector, plus one fetch in flight).

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `pause` input 1: freezes the sequencer; no state change and no pulses while high.
- `instr` input 16: fetched instruction word.
- `instr_valid` input 1: `instr` is valid this cycle.
- `zero_flag` input 1: ALU zero flag, sampled with `instr`.
- `irq_req` input 1: level-sensitive interrupt request.
- `goto` output 1: one-cycle jump pulse.
- `goto_addr` output 12: jump target; valid while `goto` is high, holds its last value otherwise.
- `ret` output 1: one-cycle pop/return pulse.
- `skip` output 1: one-cycle skip pulse.
- `interrupt` output 1: one-cycle interrupt pulse; the PC control pushes and vectors to address 4.
- `gie` output 1: global interrupt enable state.
- `depth` output 4: current return-stack occupancy.
- `stack_error` output 1: sticky overflow/underflow flag.

## Operation
Decoding uses `instr[15:12]`. Every other opcode is a plain instruction and produces no pulse.
- `4'hA` GOTO: `goto` = 1, `goto_addr` = `instr[11:0]`.
- `4'hB` SKIPZ: `skip` = 1 if `zero_flag` = 1.
- `4'hC` SKIPNZ: `skip` = 1 if `zero_flag` = 0.
- `4'hD` RET/RETFIE: `instr[0]` = 0 is RET, `instr[0]` = 1 is RETFIE.
  - Both issue `ret` and decrement `depth`.
  - RETFIE also sets `gie` in the same edge.
- `4'hE` with `instr[11:0]` = `12'h001` is EI (set `gie`); with `12'h002` it is DI (clear `gie`).

Interrupt:
- An interrupt is taken when `irq_req` & `gie` & state RUN & no flow op is decoded on that edge & `depth` < `STACK_DEPTH`.
- Taking it issues `interrupt`, clears `gie` and increments `depth`.
- The instruction sampled on that edge is discarded; the PC control re-executes it after the return.

Return-stack limits:
- RET with `depth` = 0: no `ret` pulse, `stack_error` set, `depth` stays 0.
- `irq_req` at full depth: the interrupt is not taken and stays pending (the request is level-sensitive). `stack_error` is not set.

State machine, evaluated per edge when `pause` = 0:
- RUN: accepts `instr` when `instr_valid` is high.
  - GOTO, RET, RETFIE or a taken skip → FLUSH.
  - Interrupt taken → IRQ_WAIT with counter = `IRQ_LATENCY` − 1.
- FLUSH: discards one instruction slot (`instr_valid` is ignored) → RUN.
- IRQ_WAIT: discards; decrements the counter; at 0 → RUN.

Priority on a single edge: `reset` > `pause` > flow op > interrupt > EI/DI.

## Timing
- Reset (async, immediate): all pulses 0, `goto_addr` = 0, `gie` = 0, `depth` = 0, `stack_error` = 0, state RUN.
- Reset mid-FLUSH or mid-IRQ_WAIT returns to RUN with no pulse.
- Outputs are registered. An instruction sampled at edge n produces its pulse high from edge n through edge n+1, for exactly one cycle. The PC control samples the pulse at edge n+1.
- Never more than one of `goto`/`ret`/`skip`/`interrupt` is high in any cycle.
- Back-to-back pulses are impossible: the minimum spacing is 2 cycles after GOTO/RET/skip and `IRQ_LATENCY`+1 cycles after an interrupt.
- `pause` high at edge n: the pulse from edge n−1 drops, no new pulse is issued, and the state and FLUSH/IRQ counters hold.
- `gie` and `depth` update on the same edge the corresponding pulse rises.
- `depth` width rule: 4 bits, saturating at both 0 and `STACK_DEPTH`; it never wraps.

## Test plan
- **Reset**: reset, then stream 3 plain instructions. All outputs stay 0.
- **Reset during IRQ_WAIT**: assert `reset` mid-IRQ_WAIT. All outputs clear asynchronously and the state is RUN.
- **GOTO**: `instr` = `16'hA123`. `goto` pulses one cycle later with `goto_addr` = `12'h123`. The next valid instruction (`16'hA456`) is discarded, and the one after it produces `goto_addr` = `12'h456`.
- **Skips**: SKIPZ `16'hB000` with `zero_flag` = 1 gives `skip` = 1 plus one flush. With `zero_flag` = 0 there is no pulse and no flush. SKIPNZ gives the mirrored result.
- **Interrupt**:
  - EI, then `irq_req` = 1: `interrupt` pulses, `gie` goes to 0, `depth` goes to 1.
  - The next 3 instructions are discarded.
  - RETFIE `16'hD001` then gives `ret`, `gie` = 1, `depth` = 0.
- **Overflow and underflow**:
  - Take 8 nested interrupts with EI between them: `depth` reaches 8, and a 9th `irq_req` gets no pulse.
  - 8 RETs bring `depth` to 0.
  - A 9th RET gives no `ret` pulse and `stack_error` = 1.
- **Collision**: GOTO plus `irq_req` with `gie` = 1 on the same edge. `goto` is issued first, and `interrupt` follows after the FLUSH slot.
